seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Consumer of the millisecond tick (MS_F) from the system tick divider.
- Multiplexes up to NUM_DIGITS hex/BCD digits onto a shared common-anode 7-segment bus.
- Holds each digit for DWELL_MS ticks, inserts a fixed blanking gap between digits to prevent ghosting, and commits new digit data only at frame boundaries so no frame shows a mix of old and new data.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..16).
- DWELL_MS, 2, MS_F ticks each digit is lit (>=1).
- BLANK_CYC, 50, SYS_CLK cycles all anodes are off between digits (>=1).

Ports:
- SYS_CLK  in  1  system clock; all logic on rising edge.
- SYS_RST  in  1  synchronous, active-high reset.
- MS_F  in  1  one-cycle millisecond tick strobe.
- LOAD  in  1  one-cycle strobe; capture DIGITS and DP_MASK.
- DIGITS  in  4*NUM_DIGITS  nibble i is digit i; digit 0 is least significant/rightmost.
- DP_MASK  in  NUM_DIGITS  decimal point per digit; 1 = lit.
- SEG  out  7  segments g..a, active-low, registered.
- DP  out  1  decimal point, active-low, registered.
- AN  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all-high, registered.
- FRAME_F  out  1  one-cycle pulse at each frame commit.

Behaviour:
- Reset (synchronous, SYS_RST=1 at edge):
  - SEG=7'h7F, DP=1, AN=all 1s, FRAME_F=0.
  - state=BLANK, idx=0, blank_cnt=0, dwell_cnt=0.
  - shadow, shadow_dp, disp, disp_dp=0; pending=1, so the first frame commits the shadow contents (zeros).
- Reset asserted mid-scan aborts immediately; nothing is retained.
- BLANK state:
  - AN all 1s, SEG=7'h7F, DP=1.
  - blank_cnt increments every cycle; MS_F is ignored.
  - When blank_cnt==BLANK_CYC-1: clear blank_cnt and go to SHOW.
  - On that same edge: AN[idx]<=0, SEG<=decode(nibble idx), DP<=~dp bit idx.
  - Commit rule: if idx==0 and pending, disp/disp_dp<=shadow/shadow_dp, pending<=0, FRAME_F<=1, and the nibble decoded on that edge is taken from shadow.
- SHOW state:
  - Outputs hold their values.
  - On MS_F, dwell_cnt increments.
  - When MS_F arrives with dwell_cnt==DWELL_MS-1: clear dwell_cnt, idx<=(idx==NUM_DIGITS-1)?0:idx+1, go to BLANK, and turn outputs off on the same edge.
- Digit timing:
  - Digit on-time is exactly DWELL_MS tick intervals.
  - The first interval is partial: it runs from entry into SHOW to the first MS_F.
- LOAD:
  - shadow<=DIGITS, shadow_dp<=DP_MASK, pending<=1.
  - LOAD on the commit edge: the commit uses the old shadow; the new value is captured and pending stays 1.
  - Back-to-back LOADs: the last one wins.
- Latency: LOAD to visible on digit 0 is at most one full frame plus one blank period.
- Decode font: hex 0-F, active-low, a=bit0, for example 0→7'h40, 1→7'h79, 8→7'h00, F→7'h0E.
- FRAME_F is 0 in every cycle other than a commit edge.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Zero digits above the most significant nonzero digit of disp drive SEG=7'h7F; AN is still asserted and DP still follows disp_dp.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the committed value at the BLANK→SHOW edge.
- Undefined: all digits are decoded normally.

Decomposition:
- Package seg_pkg:
  - SEG_OFF=7'h7F.
  - 16-entry font constant.
  - Scan state enum {BLANK, SHOW}.
- Sub-module seg_hex_decode: combinational 4-bit→7-bit active-low font lookup, instantiated once on the selected nibble.

Test Plan (NUM_DIGITS=4, DWELL_MS=2, BLANK_CYC=3; MS_F pulsed every 20 cycles):
- Reset then idle → SEG=7F, AN=F, DP=1 for 3 cycles; then AN=E, SEG=40 (digit 0 = 0) with FRAME_F=1 for one cycle.
- LOAD DIGITS=16'h1238, DP_MASK=4'b0100, mid-frame → old data completes the frame; next digit-0 slot shows SEG=00 with FRAME_F; digit 2 shows SEG=24, DP=0, AN=B.
- Anode sequence over 2 frames → E,F,D,F,B,F,7,F,E…; each F gap lasts exactly 3 cycles; each lit digit spans exactly 2 MS_F pulses.
- LOAD on the commit edge with 16'hAAAA after an earlier LOAD of 16'h5555 → frame shows 5s; the following frame shows A (SEG=08).
- SYS_RST asserted while AN=D → next cycle SEG=7F, AN=F, FRAME_F=0; the scan restarts at digit 0 after 3 cycles.
- With SEG_SCAN_LZB_EN and DIGITS=16'h0070 → digits 3 and 2 show SEG=7F with AN asserted; digit 1=78, digit 0=40. With 16'h0000, only digit 0 shows 40.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, font table and scan state for the 7-segment scanner.
package seg_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {BLANK, SHOW} scan_t;
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: 4-bit hex to active-low 7-segment (g..a) font lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = FONT[nib];
endmodule

// File: rtl/seg_scan.sv
// seg_scan: common-anode multiplexed 7-segment scanner with frame-boundary data commit.
// Define SEG_SCAN_LZB_EN to blank leading zero digits.
module seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DWELL_MS   = 2,
  parameter int BLANK_CYC  = 50
) (
  input  logic                    SYS_CLK,
  input  logic                    SYS_RST,
  input  logic                    MS_F,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] DIGITS,
  input  logic [NUM_DIGITS-1:0]   DP_MASK,
  output logic [6:0]              SEG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    FRAME_F
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam int DW = $clog2(DWELL_MS + 1);
  scan_t state, state_n;
  logic [IW-1:0] idx;
  logic [BW-1:0] blank_cnt;
  logic [DW-1:0] dwell_cnt;
  logic [4*NUM_DIGITS-1:0] shadow, disp, src;
  logic [NUM_DIGITS-1:0] shadow_dp, disp_dp, src_dp;
  logic pending, go_show, go_blank, commit, lzb;
  logic [3:0] nib;
  logic [6:0] dec;
  always_comb begin
    go_show  = state == BLANK && blank_cnt == BW'(BLANK_CYC - 1);
    go_blank = state == SHOW && MS_F && dwell_cnt == DW'(DWELL_MS - 1);
    state_n  = go_show ? SHOW : go_blank ? BLANK : state;
    commit   = go_show && idx == '0 && pending;
    src      = commit ? shadow : disp;
    src_dp   = commit ? shadow_dp : disp_dp;
    nib      = src[{idx, 2'b00} +: 4];
  end
`ifdef SEG_SCAN_LZB_EN
  // A digit is leading-zero when it and every digit above it are zero.
  assign lzb = idx != '0 && (src >> {idx, 2'b00}) == '0;
`else
  assign lzb = 1'b0;
`endif
  seg_hex_decode u_dec (.nib(nib), .seg(dec));
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state     <= BLANK;
      idx       <= '0;
      blank_cnt <= '0;
      dwell_cnt <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      disp      <= '0;
      disp_dp   <= '0;
      pending   <= 1'b1;
      SEG       <= SEG_OFF;
      DP        <= 1'b1;
      AN        <= '1;
      FRAME_F   <= 1'b0;
    end else begin
      state     <= state_n;
      blank_cnt <= (state == BLANK && !go_show) ? blank_cnt + 1'b1 : '0;
      FRAME_F   <= commit;
      if (state == SHOW && MS_F) dwell_cnt <= go_blank ? '0 : dwell_cnt + 1'b1;
      if (go_show) begin
        AN  <= ~(NUM_DIGITS'(1) << idx);
        SEG <= lzb ? SEG_OFF : dec;
        DP  <= ~src_dp[idx];
      end else if (go_blank) begin
        AN  <= '1;
        SEG <= SEG_OFF;
        DP  <= 1'b1;
        idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      end
      if (commit) begin
        disp    <= shadow;
        disp_dp <= shadow_dp;
        pending <= 1'b0;
      end
      // A LOAD on the commit edge is captured after the old shadow is committed.
      if (LOAD) begin
        shadow    <= DIGITS;
        shadow_dp <= DP_MASK;
        pending   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed self-checking bench for seg_scan (4 digits, dwell 2, blank 3).
module tb_seg_scan;
  logic clk = 1'b0, rst = 1'b1, ms_f = 1'b0, load = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0] dp_mask = '0, an;
  logic [6:0] seg;
  logic dp, frame_f;
  int n_chk = 0, n_fail = 0;
  logic [3:0] seq [8] = '{4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7};
  seg_scan #(.NUM_DIGITS(4), .DWELL_MS(2), .BLANK_CYC(3)) dut (
    .SYS_CLK(clk), .SYS_RST(rst), .MS_F(ms_f), .LOAD(load), .DIGITS(digits),
    .DP_MASK(dp_mask), .SEG(seg), .DP(dp), .AN(an), .FRAME_F(frame_f)
  );
  always #5 clk = ~clk;
  initial forever begin
    repeat (19) @(negedge clk);
    ms_f = 1'b1;
    @(negedge clk);
    ms_f = 1'b0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_an(input logic [3:0] exp, input string tag);
    int n = 0;
    while (an !== exp && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, an, exp);
  endtask
  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_f !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, frame_f, 1);
  endtask
  task automatic pulse_load(input logic [15:0] d, input logic [3:0] m);
    @(negedge clk);
    digits = d; dp_mask = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic restart_check(input string tag);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; check({tag, "_an1"}, an, 4'hF);
    @(posedge clk); #1; check({tag, "_an2"}, an, 4'hF);
    @(posedge clk); #1;
    check({tag, "_an3"}, an, 4'hE);
    check({tag, "_seg3"}, seg, 7'h40);
    check({tag, "_frame3"}, frame_f, 1);
    @(posedge clk); #1; check({tag, "_frame4"}, frame_f, 0);
  endtask
  initial begin
    logic [3:0] cur;
    int n, t;
    repeat (3) @(posedge clk); #1;
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    check("rst_dp", dp, 1);
    check("rst_frame", frame_f, 0);
    restart_check("start");
    wait_an(4'hD, "l1_wait_d");
    pulse_load(16'h1238, 4'b0100);
    wait_an(4'hB, "l1_wait_b_old");
    check("l1_old_seg", seg, 7'h40);
    wait_frame("l1_frame");
    check("l1_d0_an", an, 4'hE);
    check("l1_d0_seg", seg, 7'h00);
    check("l1_d0_dp", dp, 1);
    wait_an(4'hD, "l1_wait_d1");
    check("l1_d1_seg", seg, 7'h30);
    wait_an(4'hB, "l1_wait_d2");
    check("l1_d2_seg", seg, 7'h24);
    check("l1_d2_dp", dp, 0);
    wait_an(4'h7, "l1_wait_d3");
    check("l1_d3_seg", seg, 7'h79);
    for (int i = 0; i < 16; i++) begin
      cur = an; n = 0; t = 0;
      do begin
        @(posedge clk); #1;
        n++;
        if (ms_f) t++;
      end while (an === cur && n < 300);
      check("an_seq", an, seq[i % 8]);
      if (cur == 4'hF) check("gap_len", n, 3);
      else check("dwell_ticks", t, 2);
    end
    pulse_load(16'h5555, 4'b0000);
    wait_an(4'hF, "c_wait_gap");
    @(posedge clk);
    @(posedge clk);
    pulse_load(16'hAAAA, 4'b0000);
    check("c_frame", frame_f, 1);
    check("c_an", an, 4'hE);
    check("c_seg5", seg, 7'h12);
    wait_an(4'hD, "c_wait_d1");
    check("c_d1_seg5", seg, 7'h12);
    wait_an(4'h7, "c_wait_d3");
    check("c_d3_seg5", seg, 7'h12);
    wait_frame("c_frame2");
    check("c_segA", seg, 7'h08);
    wait_an(4'hD, "r_wait_d");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("r_seg", seg, 7'h7F);
    check("r_an", an, 4'hF);
    check("r_frame", frame_f, 0);
    restart_check("restart");
    pulse_load(16'h0070, 4'b0000);
    wait_frame("z_frame");
    check("z_d0_seg", seg, 7'h40);
    wait_an(4'hD, "z_wait_d1");
    check("z_d1_seg", seg, 7'h78);
    wait_an(4'hB, "z_wait_d2");
`ifdef SEG_SCAN_LZB_EN
    check("z_d2_seg", seg, 7'h7F);
`else
    check("z_d2_seg", seg, 7'h40);
`endif
    wait_an(4'h7, "z_wait_d3");
`ifdef SEG_SCAN_LZB_EN
    check("z_d3_seg", seg, 7'h7F);
`else
    check("z_d3_seg", seg, 7'h40);
`endif
    pulse_load(16'h0000, 4'b0000);
    wait_frame("z0_frame");
    check("z0_d0_seg", seg, 7'h40);
    wait_an(4'hD, "z0_wait_d1");
`ifdef SEG_SCAN_LZB_EN
    check("z0_d1_seg", seg, 7'h7F);
`else
    check("z0_d1_seg", seg, 7'h40);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
